// File: rtl/sdr_rr_arbiter.sv
// sdr_rr_arbiter: round-robin arbiter giving NUM_REQ ROM fetch ports one outstanding SDRAM read at a time.
// Define SDR_TIMEOUT_EN to add a WAIT watchdog that completes a stuck read with all-ones data and pulses timeout.
module sdr_rr_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int AW             = 25,
   parameter int DW             = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ*AW-1:0] rom_addr,
   input  logic [NUM_REQ-1:0]    rom_req,
   output logic [DW-1:0]         rom_data,
   output logic [NUM_REQ-1:0]    rom_rdy,
   output logic [AW-1:0]         sdr_addr,
   output logic                  sdr_req,
   input  logic [DW-1:0]         sdr_data,
   input  logic                  sdr_rdy,
`ifdef SDR_TIMEOUT_EN
   output logic                  timeout,
`endif
   output logic                  busy
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef enum logic {IDLE, WAIT} state_t;
   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  pending_q, pending_d, req_prev_q, rom_rdy_q, rom_rdy_d;
   logic [AW-1:0]       addr_q [NUM_REQ];
   logic [AW-1:0]       addr_d [NUM_REQ];
   logic [AW-1:0]       sdr_addr_q, sdr_addr_d;
   logic                sdr_req_q, sdr_req_d;
   logic [DW-1:0]       rom_data_q, rom_data_d;
   logic [GW-1:0]       last_grant_q, last_grant_d, grant_q, grant_d, pick, idx;
   logic                found;
`ifdef SDR_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
`endif
   // first pending port after the last winner, wrapping around
   always_comb begin
      pick  = last_grant_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
         if (!found && pending_q[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      addr_d       = addr_q;
      sdr_addr_d   = sdr_addr_q;
      sdr_req_d    = 1'b0;
      rom_data_d   = rom_data_q;
      rom_rdy_d    = '0;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
`ifdef SDR_TIMEOUT_EN
      cnt_d        = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
      timeout_d    = 1'b0;
`endif
      if (state_q == IDLE && found) begin
         sdr_addr_d      = addr_q[pick];
         sdr_req_d       = 1'b1;
         pending_d[pick] = 1'b0;
         last_grant_d    = pick;
         grant_d         = pick;
         state_d         = WAIT;
      end else if (state_q == WAIT && sdr_rdy) begin
         rom_data_d         = sdr_data;
         rom_rdy_d[grant_q] = 1'b1;
         state_d            = IDLE;
      end
`ifdef SDR_TIMEOUT_EN
      else if (state_q == WAIT && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
         rom_data_d         = {DW{1'b1}};
         rom_rdy_d[grant_q] = 1'b1;
         timeout_d          = 1'b1;
         state_d            = IDLE;
      end
`endif
      // testing the post-grant pending lets a new edge on the winning port survive its own clear
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rom_req[i] && !req_prev_q[i] && !pending_d[i]) begin
            pending_d[i] = 1'b1;
            addr_d[i]    = rom_addr[i*AW +: AW];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         req_prev_q   <= '0;
         addr_q       <= '{default: '0};
         sdr_addr_q   <= '0;
         sdr_req_q    <= 1'b0;
         rom_data_q   <= '0;
         rom_rdy_q    <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
         grant_q      <= '0;
`ifdef SDR_TIMEOUT_EN
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         req_prev_q   <= rom_req;
         addr_q       <= addr_d;
         sdr_addr_q   <= sdr_addr_d;
         sdr_req_q    <= sdr_req_d;
         rom_data_q   <= rom_data_d;
         rom_rdy_q    <= rom_rdy_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
`ifdef SDR_TIMEOUT_EN
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
`endif
      end
   end
   assign rom_data = rom_data_q;
   assign rom_rdy  = rom_rdy_q;
   assign sdr_addr = sdr_addr_q;
   assign sdr_req  = sdr_req_q;
   assign busy     = (state_q == WAIT);
`ifdef SDR_TIMEOUT_EN
   assign timeout  = timeout_q;
`endif
endmodule

// File: tb/tb_sdr_rr_arbiter.sv
// tb_sdr_rr_arbiter: vector table, directed corner sequences and random traffic against a behavioural arbiter model.
// Build with SDR_TIMEOUT_EN defined to also exercise the watchdog (limit set to 8 cycles here).
module tb_sdr_rr_arbiter;
   localparam int N = 4, AW = 25, DW = 16, TO = 8;
   logic            clk = 1'b0, reset = 1'b1;
   logic [N*AW-1:0] rom_addr = '0;
   logic [N-1:0]    rom_req = '0;
   logic [DW-1:0]   sdr_data = '0;
   logic            sdr_rdy = 1'b0;
   logic [DW-1:0]   rom_data;
   logic [N-1:0]    rom_rdy;
   logic [AW-1:0]   sdr_addr;
   logic            sdr_req, busy;
`ifdef SDR_TIMEOUT_EN
   logic            timeout;
`endif
   int n_vec = 0, n_err = 0;

   sdr_rr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_req(rom_req),
      .rom_data(rom_data), .rom_rdy(rom_rdy), .sdr_addr(sdr_addr), .sdr_req(sdr_req),
      .sdr_data(sdr_data), .sdr_rdy(sdr_rdy),
`ifdef SDR_TIMEOUT_EN
      .timeout(timeout),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // behavioural model: a set of waiting ports with their addresses and at most one read in flight
   bit            m_pend [N];
   bit            m_prev [N];
   logic [AW-1:0] m_addr [N];
   int            m_last, m_grant, m_cnt;
   bit            m_busy, m_sreq, m_tout;
   logic [AW-1:0] m_saddr;
   logic [N-1:0]  m_rrdy;
   logic [DW-1:0] m_rdata;

   function automatic void model_step();
      int g;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
         end
         m_last = N - 1; m_grant = 0; m_cnt = 0;
         m_busy = 0; m_sreq = 0; m_tout = 0;
         m_saddr = '0; m_rrdy = '0; m_rdata = '0;
         return;
      end
      g = -1; m_sreq = 0; m_rrdy = '0; m_tout = 0;
      if (!m_busy) begin
         for (int k = 1; k <= N; k++)
            if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
         if (g >= 0) begin
            m_sreq = 1; m_saddr = m_addr[g]; m_pend[g] = 0;
            m_last = g; m_grant = g; m_busy = 1; m_cnt = 0;
         end
      end else if (sdr_rdy) begin
         m_rdata = sdr_data; m_rrdy = N'(1) << m_grant; m_busy = 0;
      end
`ifdef SDR_TIMEOUT_EN
      else if (m_cnt == TO - 1) begin
         m_rdata = '1; m_rrdy = N'(1) << m_grant; m_busy = 0; m_tout = 1;
      end else m_cnt++;
`endif
      for (int i = 0; i < N; i++) begin
         if (rom_req[i] && !m_prev[i] && !m_pend[i]) begin
            m_pend[i] = 1;
            m_addr[i] = rom_addr[i*AW +: AW];
         end
         m_prev[i] = rom_req[i];
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      rom_addr[i*AW +: AW] = a;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk); #1;
      chk("sdr_req", 32'(sdr_req), 32'(m_sreq));
      chk("sdr_addr", 32'(sdr_addr), 32'(m_saddr));
      chk("rom_rdy", 32'(rom_rdy), 32'(m_rrdy));
      chk("rom_data", 32'(rom_data), 32'(m_rdata));
      chk("busy", 32'(busy), 32'(m_busy));
`ifdef SDR_TIMEOUT_EN
      chk("timeout", 32'(timeout), 32'(m_tout));
`endif
   endtask

   typedef struct {
      logic rst; logic [N-1:0] req; logic [AW-1:0] a; logic rdy; logic [DW-1:0] d;
      logic e_sreq; logic [AW-1:0] e_saddr; logic [N-1:0] e_rrdy; logic [DW-1:0] e_rdata; logic e_busy;
   } vec_t;
   vec_t tbl [$];

   initial begin
      int issues;
      // each row: inputs before the edge, outputs expected just after it; port i address = a + i
      tbl.push_back('{1'b1, 4'b0000, 25'h0,       1'b0, 16'h0,    1'b0, 25'h0,       4'b0000, 16'h0,    1'b0});
      tbl.push_back('{1'b0, 4'b0001, 25'h1234,    1'b0, 16'h0,    1'b0, 25'h0,       4'b0000, 16'h0,    1'b0});
      tbl.push_back('{1'b0, 4'b0001, 25'h1234,    1'b0, 16'h0,    1'b1, 25'h1234,    4'b0000, 16'h0,    1'b1});
      tbl.push_back('{1'b0, 4'b0001, 25'h1234,    1'b0, 16'h0,    1'b0, 25'h1234,    4'b0000, 16'h0,    1'b1});
      tbl.push_back('{1'b0, 4'b0000, 25'h1234,    1'b0, 16'h0,    1'b0, 25'h1234,    4'b0000, 16'h0,    1'b1});
      tbl.push_back('{1'b0, 4'b0000, 25'h1234,    1'b1, 16'hBEEF, 1'b0, 25'h1234,    4'b0001, 16'hBEEF, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 25'h1234,    1'b0, 16'h0,    1'b0, 25'h1234,    4'b0000, 16'hBEEF, 1'b0});
      tbl.push_back('{1'b1, 4'b1111, 25'h100,     1'b0, 16'h0,    1'b0, 25'h0,       4'b0000, 16'h0,    1'b0});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b0, 16'h0,    1'b0, 25'h0,       4'b0000, 16'h0,    1'b0});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b0, 16'h0,    1'b1, 25'h100,     4'b0000, 16'h0,    1'b1});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b1, 16'h00A0, 1'b0, 25'h100,     4'b0001, 16'h00A0, 1'b0});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b0, 16'h0,    1'b1, 25'h101,     4'b0000, 16'h00A0, 1'b1});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b1, 16'h00A1, 1'b0, 25'h101,     4'b0010, 16'h00A1, 1'b0});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b0, 16'h0,    1'b1, 25'h102,     4'b0000, 16'h00A1, 1'b1});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b1, 16'h00A2, 1'b0, 25'h102,     4'b0100, 16'h00A2, 1'b0});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b0, 16'h0,    1'b1, 25'h103,     4'b0000, 16'h00A2, 1'b1});
      tbl.push_back('{1'b0, 4'b1111, 25'h100,     1'b1, 16'h00A3, 1'b0, 25'h103,     4'b1000, 16'h00A3, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 25'h100,     1'b0, 16'h0,    1'b0, 25'h103,     4'b0000, 16'h00A3, 1'b0});
      tbl.push_back('{1'b0, 4'b1010, 25'h200,     1'b0, 16'h0,    1'b0, 25'h103,     4'b0000, 16'h00A3, 1'b0});
      tbl.push_back('{1'b0, 4'b1010, 25'h200,     1'b0, 16'h0,    1'b1, 25'h201,     4'b0000, 16'h00A3, 1'b1});
      tbl.push_back('{1'b0, 4'b1010, 25'h200,     1'b1, 16'h00B1, 1'b0, 25'h201,     4'b0010, 16'h00B1, 1'b0});
      tbl.push_back('{1'b0, 4'b1010, 25'h200,     1'b0, 16'h0,    1'b1, 25'h203,     4'b0000, 16'h00B1, 1'b1});
      tbl.push_back('{1'b0, 4'b1010, 25'h200,     1'b1, 16'h00B3, 1'b0, 25'h203,     4'b1000, 16'h00B3, 1'b0});
      foreach (tbl[r]) begin
         reset = tbl[r].rst; rom_req = tbl[r].req; sdr_rdy = tbl[r].rdy; sdr_data = tbl[r].d;
         for (int i = 0; i < N; i++) set_addr(i, tbl[r].a + AW'(i));
         model_step();
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_sdr_req", r), 32'(sdr_req), 32'(tbl[r].e_sreq));
         chk($sformatf("tbl%0d_sdr_addr", r), 32'(sdr_addr), 32'(tbl[r].e_saddr));
         chk($sformatf("tbl%0d_rom_rdy", r), 32'(rom_rdy), 32'(tbl[r].e_rrdy));
         chk($sformatf("tbl%0d_rom_data", r), 32'(rom_data), 32'(tbl[r].e_rdata));
         chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
      end
      sdr_rdy = 0;

      // new edge on port2 while port2 is being served: second read uses the new address
      reset = 1; rom_req = '0; cyc(); reset = 0;
      rom_req = 4'b0100; set_addr(2, 25'hAAAA); cyc();
      cyc(); chk("t3_issue1", 32'(sdr_req), 32'd1); chk("t3_addr1", 32'(sdr_addr), 32'hAAAA);
      rom_req = 4'b0000; cyc();
      rom_req = 4'b0100; set_addr(2, 25'hBBBB); cyc();
      sdr_rdy = 1; sdr_data = 16'h1111; cyc(); chk("t3_done1", 32'(rom_rdy), 32'b0100);
      sdr_rdy = 0; cyc(); chk("t3_issue2", 32'(sdr_req), 32'd1); chk("t3_addr2", 32'(sdr_addr), 32'hBBBB);
      sdr_rdy = 1; cyc(); sdr_rdy = 0; rom_req = '0; cyc();

      // port2 edge in the very cycle port2 wins: old address goes out, new one follows
      rom_req = 4'b0101; set_addr(0, 25'h10); set_addr(2, 25'h20); cyc();
      cyc(); chk("tg_addr0", 32'(sdr_addr), 32'h10);
      rom_req = 4'b0001; cyc();
      sdr_rdy = 1; cyc();
      sdr_rdy = 0; rom_req = 4'b0101; set_addr(2, 25'h30); cyc();
      chk("tg_issue_old", 32'(sdr_req), 32'd1); chk("tg_addr_old", 32'(sdr_addr), 32'h20);
      sdr_rdy = 1; cyc();
      sdr_rdy = 0; cyc(); chk("tg_issue_new", 32'(sdr_req), 32'd1); chk("tg_addr_new", 32'(sdr_addr), 32'h30);
      sdr_rdy = 1; cyc(); sdr_rdy = 0; cyc(); chk("tg_idle", 32'(busy), 32'd0);

      // reset while WAIT, then a stray completion
      rom_req = '0; cyc();
      rom_req = 4'b0001; set_addr(0, 25'h55); cyc();
      cyc(); chk("t4_busy", 32'(busy), 32'd1);
      rom_req = '0; reset = 1; cyc(); reset = 0; chk("t4_rst_busy", 32'(busy), 32'd0);
      cyc();
      sdr_rdy = 1; cyc();
      chk("t4_rdy", 32'(rom_rdy), 32'd0); chk("t4_busy2", 32'(busy), 32'd0); chk("t4_sreq", 32'(sdr_req), 32'd0);
      sdr_rdy = 0; cyc(); chk("t4_sreq2", 32'(sdr_req), 32'd0);

      // held request is served once; another port completes meanwhile
      reset = 1; cyc(); reset = 0;
      rom_req = 4'b0001; set_addr(0, 25'h77); set_addr(1, 25'h88); cyc();
      cyc(); chk("t5_first", 32'(sdr_addr), 32'h77);
      issues = 0;
      for (int i = 0; i < 12; i++) begin
         sdr_rdy = (i == 2 || i == 7);
         rom_req = (i >= 3) ? 4'b0011 : 4'b0001;
         cyc();
         if (sdr_req) begin
            issues++;
            chk("t5_addr", 32'(sdr_addr), 32'h88);
         end
      end
      chk("t5_issues", 32'(issues), 32'd1);
      sdr_rdy = 0; rom_req = 4'b0010; cyc();
      rom_req = 4'b0011; cyc();
      cyc(); chk("t5_reissue", 32'(sdr_req), 32'd1); chk("t5_readdr", 32'(sdr_addr), 32'h77);
      sdr_rdy = 1; cyc(); sdr_rdy = 0; rom_req = '0; cyc();

`ifdef SDR_TIMEOUT_EN
      reset = 1; cyc(); reset = 0;
      rom_req = 4'b0001; set_addr(0, 25'h99); cyc();
      cyc(); rom_req = '0;
      for (int k = 1; k <= TO; k++) begin
         cyc();
         if (k < TO) chk("to_early", 32'(rom_rdy), 32'd0);
         else begin
            chk("to_rdy", 32'(rom_rdy), 32'b0001);
            chk("to_data", 32'(rom_data), 32'hFFFF);
            chk("to_flag", 32'(timeout), 32'd1);
         end
      end
`endif

      // random traffic, random completions (some while idle) and occasional resets
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) rom_req[i] = ~rom_req[i];
            set_addr(i, AW'($urandom));
         end
         sdr_rdy = ($urandom_range(0, 3) == 0);
         sdr_data = DW'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
